miner_result_tx: RTL and testbench

MINER_RESULT_TX -- requirements
Module: miner_result_tx

---
 rtl/miner_pkg.sv | 24 ++
 rtl/miner_result_tx_if.sv | 15 +
 rtl/hash_lt_cmp.sv | 8 +
 rtl/miner_result_tx.sv | 42 ++++
 tb/tb_miner_result_tx.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/miner_pkg.sv
// miner_pkg: shared state encoding, frame constants and frame byte selection
package miner_pkg;
  typedef enum logic [1:0] {IDLE, COMPARE, SEND} rtx_state_t;
  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int FRAME_LEN = 10;
  localparam int NONCE_W = 32;
  function automatic logic [7:0] frame_byte(input logic [3:0] i, input logic [NONCE_W-1:0] n, input logic [31:0] h);
    logic [7:0] chk;
    chk = n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0] ^ h[31:24] ^ h[23:16] ^ h[15:8] ^ h[7:0];
    case (i)
      4'd0: return FRAME_HDR;
      4'd1: return n[31:24];
      4'd2: return n[23:16];
      4'd3: return n[15:8];
      4'd4: return n[7:0];
      4'd5: return h[31:24];
      4'd6: return h[23:16];
      4'd7: return h[15:8];
      4'd8: return h[7:0];
      4'd9: return chk;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/miner_result_tx_if.sv
// miner_result_tx_if: hash result in, framed byte stream out
interface miner_result_tx_if;
  import miner_pkg::*;
  logic finished;
  logic [255:0] hash_out;
  logic [NONCE_W-1:0] nonce;
  logic [255:0] target;
  logic tx_ready;
  logic send_data;
  logic [7:0] tx_data;
  logic tx_valid;
  logic busy;
  modport master(output finished, hash_out, nonce, target, tx_ready, input send_data, tx_data, tx_valid, busy);
  modport slave(input finished, hash_out, nonce, target, tx_ready, output send_data, tx_data, tx_valid, busy);
endinterface

// File: rtl/hash_lt_cmp.sv
// hash_lt_cmp: 256-bit unsigned strict less-than
module hash_lt_cmp (
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic         lt
);
  assign lt = a < b;
endmodule

// File: rtl/miner_result_tx.sv
// miner_result_tx: checks a finished hash against target and streams a 10-byte golden-nonce frame
module miner_result_tx
  import miner_pkg::*;
(
  input logic clk,
  input logic rst,
  miner_result_tx_if.slave bus
);
  rtx_state_t state, state_n;
  logic [3:0] idx;
  logic [255:0] hash_q;
  logic [NONCE_W-1:0] nonce_q;
  logic hit, last;
  hash_lt_cmp u_cmp (.a(hash_q), .b(bus.target), .lt(hit));
  assign last = state == SEND && bus.tx_ready && idx == 4'(FRAME_LEN - 1);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (bus.finished ? COMPARE : IDLE) :
              state == COMPARE ? (hit ? SEND : IDLE) :
              (last ? IDLE : SEND);
  // capture only from IDLE so pulses arriving mid-frame leave the frame intact
  always_ff @(posedge clk)
    if (rst) begin
      idx <= 4'd0;
      hash_q <= '0;
      nonce_q <= '0;
    end else begin
      if (state == IDLE && bus.finished) begin
        hash_q <= bus.hash_out;
        nonce_q <= bus.nonce;
      end
      idx <= (state != SEND || last) ? 4'd0 : bus.tx_ready ? idx + 4'd1 : idx;
    end
  always_comb begin
    bus.send_data = state == SEND;
    bus.tx_valid = state == SEND;
    bus.tx_data = state == SEND ? frame_byte(idx, nonce_q, hash_q[255:224]) : 8'h00;
    bus.busy = state != IDLE;
  end
endmodule

// File: tb/tb_miner_result_tx.sv
// tb_miner_result_tx: scoreboard bench for the golden-nonce frame transmitter
module tb_miner_result_tx;
  import miner_pkg::*;
  logic clk = 0;
  logic rst = 1;
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  localparam logic [255:0] TGT = 256'd1 << 236;
  localparam logic [255:0] HIT = {32'h0, {224{1'b1}}};
  miner_result_tx_if bus();
  miner_result_tx dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] n, input logic [255:0] h);
    logic [7:0] b[8];
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 4; i++) begin
      b[i] = n[31-8*i -: 8];
      b[i+4] = h[255-8*i -: 8];
    end
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      c = c ^ b[i];
    end
    exp_q.push_back(c);
  endtask

  task automatic pulse(input logic [31:0] n, input logic [255:0] h, input bit hit);
    bus.nonce = n;
    bus.hash_out = h;
    bus.finished = 1;
    tick;
    bus.finished = 0;
    if (hit) push_frame(n, h);
  endtask

  task automatic test_reset;
    rst = 1;
    bus.finished = 1;
    bus.tx_ready = 1;
    tick;
    tick;
    tests++;
    if (bus.busy !== 1'b0 || bus.send_data !== 1'b0 || bus.tx_valid !== 1'b0)
      begin fails++; $display("FAIL reset_ctrl: busy/send/valid=%b%b%b want 000", bus.busy, bus.send_data, bus.tx_valid); end
    tests++;
    if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", bus.tx_data); end
    tests++;
    if (dut.nonce_q !== 32'h0 || dut.hash_q !== 256'h0) begin fails++; $display("FAIL reset_capture: nonce_q=%h want 0", dut.nonce_q); end
    rst = 0;
    bus.finished = 0;
    tick;
  endtask

  task automatic test_hit;
    logic [7:0] e;
    int cnt;
    cnt = 0;
    bus.target = TGT;
    bus.tx_ready = 1;
    pulse(32'h1234_5678, HIT, 1);
    tests++;
    if (bus.busy !== 1'b1 || bus.send_data !== 1'b0) begin fails++; $display("FAIL hit_compare: busy=%b send=%b want 1 0", bus.busy, bus.send_data); end
    for (int c = 0; c < 14; c++) begin
      tick;
      if (c == 0) begin
        tests++;
        if (bus.send_data !== 1'b1 || bus.tx_valid !== 1'b1) begin fails++; $display("FAIL hit_latency: send=%b valid=%b want 1 1", bus.send_data, bus.tx_valid); end
      end
      if (bus.send_data) cnt++;
      if (bus.tx_valid && bus.tx_ready) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL hit_extra: got %h want none", bus.tx_data); end
        else begin e = exp_q.pop_front(); if (bus.tx_data !== e) begin fails++; $display("FAIL hit_byte: got %h want %h", bus.tx_data, e); end end
      end
    end
    tests++;
    if (cnt != 10) begin fails++; $display("FAIL hit_send_cycles: got %0d want 10", cnt); end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL hit_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_miss;
    int seen, bsy;
    for (int k = 0; k < 2; k++) begin
      seen = 0;
      bsy = 0;
      bus.target = k == 0 ? HIT : 256'd0;
      pulse(32'h0BAD_F00D, k == 0 ? HIT : 256'd0, 0);
      tests++;
      if (bus.busy !== 1'b1) begin fails++; $display("FAIL miss_busy%0d: got %b want 1", k, bus.busy); end
      for (int c = 0; c < 6; c++) begin
        tick;
        if (bus.tx_valid || bus.send_data) seen++;
        if (bus.busy) bsy++;
      end
      tests++;
      if (seen != 0) begin fails++; $display("FAIL miss_tx%0d: got %0d active cycles want 0", k, seen); end
      tests++;
      if (bsy != 0) begin fails++; $display("FAIL miss_idle%0d: got %0d busy cycles want 0", k, bsy); end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] e, prev;
    logic [3:0] pat;
    bit stall;
    pat = 4'b1001;
    stall = 0;
    prev = 8'h00;
    bus.target = TGT;
    bus.tx_ready = 1;
    pulse(32'h1234_5678, HIT, 1);
    for (int c = 0; c < 50; c++) begin
      tick;
      bus.tx_ready = pat[c % 4];
      if (bus.tx_valid && stall) begin
        tests++;
        if (bus.tx_data !== prev) begin fails++; $display("FAIL bp_stable: got %h want %h", bus.tx_data, prev); end
      end
      if (bus.tx_valid && bus.tx_ready) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL bp_extra: got %h want none", bus.tx_data); end
        else begin e = exp_q.pop_front(); if (bus.tx_data !== e) begin fails++; $display("FAIL bp_byte: got %h want %h", bus.tx_data, e); end end
      end
      stall = bus.tx_valid && !bus.tx_ready;
      prev = bus.tx_data;
    end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL bp_missing: got %0d left want 0", exp_q.size()); end
    bus.tx_ready = 1;
  endtask

  task automatic test_ignored;
    logic [7:0] e;
    int bsy;
    bsy = 0;
    bus.target = TGT;
    bus.tx_ready = 1;
    pulse(32'h1234_5678, HIT, 1);
    bus.nonce = 32'hDEAD_BEEF;
    bus.hash_out = 256'd0;
    for (int c = 0; c < 12; c++) begin
      tick;
      bus.finished = c == 3 || (bus.tx_valid && exp_q.size() == 1);
      if (bus.tx_valid && bus.tx_ready) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL ign_extra: got %h want none", bus.tx_data); end
        else begin e = exp_q.pop_front(); if (bus.tx_data !== e) begin fails++; $display("FAIL ign_byte: got %h want %h", bus.tx_data, e); end end
      end
    end
    bus.finished = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (bus.busy || bus.tx_valid) bsy++;
    end
    tests++;
    if (bsy != 0) begin fails++; $display("FAIL ign_second_frame: got %0d busy cycles want 0", bsy); end
    tests++;
    if (dut.nonce_q !== 32'h1234_5678) begin fails++; $display("FAIL ign_capture: got %h want 12345678", dut.nonce_q); end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL ign_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    bit arm, done;
    logic [255:0] hb;
    arm = 0;
    done = 0;
    hb = {32'h0000_0ABC, 224'd5};
    bus.target = TGT;
    bus.tx_ready = 1;
    pulse(32'h0102_0304, HIT, 1);
    for (int c = 0; c < 30; c++) begin
      tick;
      bus.finished = 0;
      if (arm) begin
        bus.nonce = 32'hCAFE_0001;
        bus.hash_out = hb;
        bus.finished = 1;
        push_frame(32'hCAFE_0001, hb);
        arm = 0;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL b2b_extra: got %h want none", bus.tx_data); end
        else begin e = exp_q.pop_front(); if (bus.tx_data !== e) begin fails++; $display("FAIL b2b_byte: got %h want %h", bus.tx_data, e); end end
        if (exp_q.size() == 0 && !done) begin arm = 1; done = 1; end
      end
    end
    bus.finished = 0;
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_abort;
    logic [7:0] e;
    int acc, seen;
    acc = 0;
    seen = 0;
    bus.target = TGT;
    bus.tx_ready = 1;
    pulse(32'h1234_5678, HIT, 1);
    for (int c = 0; c < 20; c++) begin
      tick;
      if (acc == 5) break;
      if (bus.tx_valid && bus.tx_ready) begin
        acc++;
        tests++;
        e = exp_q.pop_front();
        if (bus.tx_data !== e) begin fails++; $display("FAIL abort_byte: got %h want %h", bus.tx_data, e); end
      end
    end
    rst = 1;
    bus.finished = 1;
    tick;
    rst = 0;
    bus.finished = 0;
    exp_q.delete();
    tests++;
    if (bus.tx_valid !== 1'b0 || bus.send_data !== 1'b0 || bus.busy !== 1'b0)
      begin fails++; $display("FAIL abort_stop: valid/send/busy=%b%b%b want 000", bus.tx_valid, bus.send_data, bus.busy); end
    for (int c = 0; c < 4; c++) begin
      tick;
      if (bus.tx_valid || bus.busy) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL abort_quiet: got %0d active cycles want 0", seen); end
    pulse(32'hA1B2_C3D4, HIT, 1);
    for (int c = 0; c < 14; c++) begin
      tick;
      if (c == 0) begin
        tests++;
        if (bus.tx_data !== 8'hA5) begin fails++; $display("FAIL abort_restart_hdr: got %h want a5", bus.tx_data); end
      end
      if (bus.tx_valid && bus.tx_ready) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL abort_extra: got %h want none", bus.tx_data); end
        else begin e = exp_q.pop_front(); if (bus.tx_data !== e) begin fails++; $display("FAIL abort_restart_byte: got %h want %h", bus.tx_data, e); end end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL abort_missing: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    bus.finished = 0;
    bus.hash_out = '0;
    bus.nonce = '0;
    bus.target = '0;
    bus.tx_ready = 0;
    test_reset;
    test_hit;
    test_miss;
    test_backpressure;
    test_ignored;
    test_back_to_back;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
